// File: rtl/adder_axil_ctrl.sv
// adder_axil_ctrl
// ---------------------------------------------------------------------------
// AXI4-Lite master sequencer for the memory-mapped adder slave. It accepts
// one job (operands A and B) on a valid/ready command port. It then does the
// following on the bus, in order:
//   1. write A to BASE_ADDR+0
//   2. write B to BASE_ADDR+4
//   3. read the sum from BASE_ADDR+8
//   4. read the overflow flag from BASE_ADDR+12 (bit 0)
// The sum, overflow and a sticky error flag are returned on a valid/ready
// response port.
//
// Optional feature macro: ADDER_CTRL_TIMEOUT_EN
//   When defined, each bus phase has a 16-bit watchdog. A phase that stays
//   incomplete for TIMEOUT_CYCLES cycles is abandoned and the job is reported
//   with rsp_err=1 and rsp_sum=0.
//   When undefined, phases wait indefinitely.
//
// Ports
//   m1_axi_aclk, m1_axi_areset    clock, async active-high reset
//   cmd_valid/cmd_ready           job handshake; cmd_a/cmd_b are the operands
//   rsp_valid/rsp_ready           result handshake; rsp_sum, rsp_ovf, rsp_err
//   m1_axi_aw*/w*/b*/ar*/r*       AXI4-Lite master channels to the adder
// ---------------------------------------------------------------------------
module adder_axil_ctrl #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_sum,
  output logic                    rsp_ovf,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic [1:0]              m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic [1:0]              m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_A   = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] ADDR_B   = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SUM = BASE_ADDR + ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OVF = BASE_ADDR + ADDR_WIDTH'(12);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_SUM, RD_OVF, DONE} state_t;

  state_t                  state, state_n;
  logic [DATA_WIDTH-1:0]   op_b, op_b_n;
  logic                    aw_done, aw_done_n, w_done, w_done_n, b_done, b_done_n;
  logic                    ar_done, ar_done_n, r_done, r_done_n;
  logic [ADDR_WIDTH-1:0]   awaddr_n, araddr_n;
  logic [DATA_WIDTH-1:0]   wdata_n, rsp_sum_n;
  logic [DATA_WIDTH/8-1:0] wstrb_n;
  logic                    awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic                    rsp_valid_n, rsp_ovf_n, rsp_err_n;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic wr_complete, rd_complete;

  // Only the error bit of each response code matters here.
  logic unused_resp_bits;
  assign unused_resp_bits = m1_axi_bresp[0] ^ m1_axi_rresp[0];

  assign aw_hs = m1_axi_awvalid & m1_axi_awready;
  assign w_hs  = m1_axi_wvalid  & m1_axi_wready;
  assign b_hs  = m1_axi_bvalid  & m1_axi_bready;
  assign ar_hs = m1_axi_arvalid & m1_axi_arready;
  assign r_hs  = m1_axi_rvalid  & m1_axi_rready;

  // A handshake in the current cycle counts as done, so a phase can finish in
  // the same cycle its last handshake happens (zero-wait slave: one cycle).
  assign wr_complete = (aw_done | aw_hs) & (w_done | w_hs) & (b_done | b_hs);
  assign rd_complete = (ar_done | ar_hs) & (r_done | r_hs);

  // cmd_ready is the only output decoded directly from the state register.
  assign cmd_ready = (state == IDLE);

`ifdef ADDER_CTRL_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt, wd_cnt_n;
  logic        in_phase, phase_complete;

  assign in_phase       = (state == WR_A) || (state == WR_B) ||
                          (state == RD_SUM) || (state == RD_OVF);
  assign phase_complete = ((state == WR_A) || (state == WR_B)) ? wr_complete
                                                               : rd_complete;
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

  // Next-state and next-output logic. Every output except cmd_ready is a
  // register, so this block computes the value each one takes at the next
  // edge. Entering a phase raises that phase's valid/ready set together and
  // clears its done flags. Each valid/ready then falls on its own handshake.
  always_comb begin
    state_n     = state;
    op_b_n      = op_b;
    aw_done_n   = aw_done;
    w_done_n    = w_done;
    b_done_n    = b_done;
    ar_done_n   = ar_done;
    r_done_n    = r_done;
    awaddr_n    = m1_axi_awaddr;
    araddr_n    = m1_axi_araddr;
    wdata_n     = m1_axi_wdata;
    wstrb_n     = m1_axi_wstrb;
    awvalid_n   = m1_axi_awvalid;
    wvalid_n    = m1_axi_wvalid;
    bready_n    = m1_axi_bready;
    arvalid_n   = m1_axi_arvalid;
    rready_n    = m1_axi_rready;
    rsp_valid_n = rsp_valid;
    rsp_sum_n   = rsp_sum;
    rsp_ovf_n   = rsp_ovf;
    rsp_err_n   = rsp_err;
`ifdef ADDER_CTRL_TIMEOUT_EN
    wd_cnt_n    = '0;
`endif

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          op_b_n    = cmd_b;
          rsp_err_n = 1'b0;
          awaddr_n  = ADDR_A;
          wdata_n   = cmd_a;
          wstrb_n   = '1;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          bready_n  = 1'b1;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          b_done_n  = 1'b0;
          state_n   = WR_A;
        end
      end

      WR_A, WR_B: begin
        if (aw_hs) begin
          awvalid_n = 1'b0;
          aw_done_n = 1'b1;
        end
        if (w_hs) begin
          wvalid_n = 1'b0;
          w_done_n = 1'b1;
        end
        if (b_hs) begin
          bready_n = 1'b0;
          b_done_n = 1'b1;
          if (m1_axi_bresp[1]) rsp_err_n = 1'b1;
        end
        if (wr_complete) begin
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          b_done_n  = 1'b0;
          if (state == WR_A) begin
            awaddr_n  = ADDR_B;
            wdata_n   = op_b;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            bready_n  = 1'b1;
            state_n   = WR_B;
          end else begin
            wstrb_n   = '0;
            araddr_n  = ADDR_SUM;
            arvalid_n = 1'b1;
            rready_n  = 1'b1;
            ar_done_n = 1'b0;
            r_done_n  = 1'b0;
            state_n   = RD_SUM;
          end
        end
      end

      RD_SUM, RD_OVF: begin
        if (ar_hs) begin
          arvalid_n = 1'b0;
          ar_done_n = 1'b1;
        end
        if (r_hs) begin
          rready_n = 1'b0;
          r_done_n = 1'b1;
          if (state == RD_SUM) rsp_sum_n = m1_axi_rdata;
          else                 rsp_ovf_n = m1_axi_rdata[0];
          if (m1_axi_rresp[1]) rsp_err_n = 1'b1;
        end
        if (rd_complete) begin
          ar_done_n = 1'b0;
          r_done_n  = 1'b0;
          if (state == RD_SUM) begin
            araddr_n  = ADDR_OVF;
            arvalid_n = 1'b1;
            rready_n  = 1'b1;
            state_n   = RD_OVF;
          end else begin
            rsp_valid_n = 1'b1;
            state_n     = DONE;
          end
        end
      end

      DONE: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase

`ifdef ADDER_CTRL_TIMEOUT_EN
    // The watchdog counts the incomplete cycles of the current phase. On the
    // last allowed cycle it abandons the bus and reports a failed job.
    if (in_phase && !phase_complete) begin
      wd_cnt_n = wd_cnt + 16'd1;
      if (wd_cnt == TIMEOUT_LIMIT) begin
        wd_cnt_n    = '0;
        awvalid_n   = 1'b0;
        wvalid_n    = 1'b0;
        bready_n    = 1'b0;
        arvalid_n   = 1'b0;
        rready_n    = 1'b0;
        rsp_err_n   = 1'b1;
        rsp_sum_n   = '0;
        rsp_valid_n = 1'b1;
        state_n     = DONE;
      end
    end
`endif
  end

  // State and output registers. Reset clears everything immediately; any bus
  // transaction in progress is simply abandoned.
  always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
    if (m1_axi_areset) begin
      state          <= IDLE;
      op_b           <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      b_done         <= 1'b0;
      ar_done        <= 1'b0;
      r_done         <= 1'b0;
      m1_axi_awaddr  <= '0;
      m1_axi_araddr  <= '0;
      m1_axi_wdata   <= '0;
      m1_axi_wstrb   <= '0;
      m1_axi_awvalid <= 1'b0;
      m1_axi_wvalid  <= 1'b0;
      m1_axi_bready  <= 1'b0;
      m1_axi_arvalid <= 1'b0;
      m1_axi_rready  <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_sum        <= '0;
      rsp_ovf        <= 1'b0;
      rsp_err        <= 1'b0;
`ifdef ADDER_CTRL_TIMEOUT_EN
      wd_cnt         <= '0;
`endif
    end else begin
      state          <= state_n;
      op_b           <= op_b_n;
      aw_done        <= aw_done_n;
      w_done         <= w_done_n;
      b_done         <= b_done_n;
      ar_done        <= ar_done_n;
      r_done         <= r_done_n;
      m1_axi_awaddr  <= awaddr_n;
      m1_axi_araddr  <= araddr_n;
      m1_axi_wdata   <= wdata_n;
      m1_axi_wstrb   <= wstrb_n;
      m1_axi_awvalid <= awvalid_n;
      m1_axi_wvalid  <= wvalid_n;
      m1_axi_bready  <= bready_n;
      m1_axi_arvalid <= arvalid_n;
      m1_axi_rready  <= rready_n;
      rsp_valid      <= rsp_valid_n;
      rsp_sum        <= rsp_sum_n;
      rsp_ovf        <= rsp_ovf_n;
      rsp_err        <= rsp_err_n;
`ifdef ADDER_CTRL_TIMEOUT_EN
      wd_cnt         <= wd_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_adder_axil_ctrl.sv
// tb_adder_axil_ctrl
// ---------------------------------------------------------------------------
// Self-checking bench for adder_axil_ctrl.
//
// The bench contains a behavioural adder slave whose per-channel wait cycles
// can be changed between jobs. Each job's result and latency are predicted
// from the job's operands and the slave's delay settings. Jobs are built from
// randomized and directed operands.
//
// Optional feature macro: ADDER_CTRL_TIMEOUT_EN. When it is defined, the
// watchdog scenario is also exercised.
// ---------------------------------------------------------------------------
module tb_adder_axil_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [DW-1:0] cmd_a, cmd_b;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_sum;
  logic          rsp_ovf, rsp_err;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  int checks = 0;
  int errors = 0;

  // Slave configuration: wait cycles per channel, plus error injection on the
  // sum read.
  int   aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic err_on_sum = 1'b0;

  // Slave state.
  logic [DW-1:0] reg_a, reg_b, aw_data_l;
  logic [AW-1:0] aw_addr_l, raddr_l, c_waddr, c_raddr;
  logic [DW-1:0] c_wdata;
  logic          aw_got, w_got, b_pend, r_pend;
  int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int            wr_count, ovf_reads, bad_strb;
  logic [DW:0]   slave_total;

  always #5 clk = ~clk;

  adder_axil_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR('0), .TIMEOUT_CYCLES(4)
  ) dut (
    .m1_axi_aclk(clk), .m1_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(awready),
    .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid),
    .m1_axi_wready(wready), .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid),
    .m1_axi_bready(bready), .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid),
    .m1_axi_arready(arready), .m1_axi_rdata(rdata), .m1_axi_rresp(rresp),
    .m1_axi_rvalid(rvalid), .m1_axi_rready(rready)
  );

  // Slave responses. A B response follows the W handshake after b_dly cycles,
  // independent of AW, and may appear in the same cycle as W when b_dly is 0.
  // R follows AR in the same way.
  always_comb begin
    awready     = awvalid && (aw_cnt >= aw_dly);
    wready      = wvalid && (w_cnt >= w_dly);
    bvalid      = (b_pend || (wvalid && wready)) && (b_cnt >= b_dly);
    bresp       = 2'b00;
    arready     = arvalid && (ar_cnt >= ar_dly);
    rvalid      = (r_pend || (arvalid && arready)) && (r_cnt >= r_dly);
    c_raddr     = r_pend ? raddr_l : araddr;
    c_waddr     = (awvalid && awready) ? awaddr : aw_addr_l;
    c_wdata     = (wvalid && wready) ? wdata : aw_data_l;
    slave_total = {1'b0, reg_a} + {1'b0, reg_b};
    rdata       = '0;
    if (c_raddr == 8'd8)  rdata = slave_total[DW-1:0];
    if (c_raddr == 8'd12) rdata = {{(DW-1){1'b0}}, slave_total[DW]};
    rresp       = (err_on_sum && c_raddr == 8'd8) ? 2'b10 : 2'b00;
  end

  // Slave state. A register write is committed once both address and data
  // have been accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a <= '0; reg_b <= '0; aw_data_l <= '0; aw_addr_l <= '0; raddr_l <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      wr_count <= 0; ovf_reads <= 0; bad_strb <= 0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) begin aw_addr_l <= awaddr; aw_got <= 1'b1; end
      if (wvalid && wready) begin
        aw_data_l <= wdata;
        w_got     <= 1'b1;
        if (wstrb != 4'hF) bad_strb <= bad_strb + 1;
      end
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        if (c_waddr == 8'd0) reg_a <= c_wdata;
        if (c_waddr == 8'd4) reg_b <= c_wdata;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
        wr_count <= wr_count + 1;
      end
      if (bvalid && bready) begin
        b_pend <= 1'b0; b_cnt <= 0;
      end else if (b_pend || (wvalid && wready)) begin
        b_pend <= 1'b1; b_cnt <= b_cnt + 1;
      end
      if (arvalid && arready) raddr_l <= araddr;
      if (rvalid && rready) begin
        r_pend <= 1'b0; r_cnt <= 0;
        if (c_raddr == 8'd12) ovf_reads <= ovf_reads + 1;
      end else if (r_pend || (arvalid && arready)) begin
        r_pend <= 1'b1; r_cnt <= r_cnt + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one job from a negedge. It predicts the result with plain
  // arithmetic. It predicts the latency from the slave delays: a write phase
  // waits for its slowest channel, and a read waits for AR then R.
  // hold = number of cycles rsp_ready is kept low.
  task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input int hold, input logic exp_err);
    logic [DW:0] ref_total;
    int wr_wait, exp_lat, lat, guard, ovf_before;
    ref_total = {1'b0, a} + {1'b0, b};
    wr_wait   = aw_dly;
    if (w_dly > wr_wait)         wr_wait = w_dly;
    if (w_dly + b_dly > wr_wait) wr_wait = w_dly + b_dly;
    exp_lat   = 5 + 2 * wr_wait + 2 * (ar_dly + r_dly);
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    ovf_before = ovf_reads;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
    checkOutput("rsp_valid", rsp_valid, 1);
    checkOutput("latency", lat, exp_lat);
    checkOutput("rsp_sum", rsp_sum, ref_total[DW-1:0]);
    checkOutput("rsp_ovf", rsp_ovf, ref_total[DW]);
    checkOutput("rsp_err", rsp_err, exp_err);
    checkOutput("ovf_read_issued", ovf_reads - ovf_before, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", rsp_valid, 1);
      checkOutput("hold_sum", rsp_sum, ref_total[DW-1:0]);
      checkOutput("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_drop", rsp_valid, 0);
    checkOutput("cmd_ready_back", cmd_ready, 1);
  endtask

  int guard_main;
  int lat_main;
  logic [DW-1:0] ra, rb;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] reset values");
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    checkOutput("rst_addr", {awaddr, araddr}, 0);
    checkOutput("rst_wdata_wstrb", {wdata, wstrb}, 0);
    checkOutput("rst_rsp", {rsp_sum, rsp_ovf, rsp_err}, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] zero-wait jobs");
    applyStimulus(32'd5, 32'd7, 0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 10, 1'b0);

    $display("[TB] delayed awready");
    aw_dly = 3; b_dly = 1;
    applyStimulus(32'h1234_5678, 32'h1111_1111, 0, 1'b0);
    aw_dly = 0; b_dly = 0;

    $display("[TB] error on sum read");
    err_on_sum = 1'b1;
    applyStimulus(32'd100, 32'd23, 0, 1'b1);
    err_on_sum = 1'b0;

    $display("[TB] randomized jobs");
    for (int i = 0; i < 6; i++) begin
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      b_dly  = $urandom_range(0, 2);
      ar_dly = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 2);
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 1) begin ra[DW-1] = 1'b1; rb[DW-1] = 1'b1; end
      applyStimulus(ra, rb, i % 3, 1'b0);
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    checkOutput("wstrb_all_ones", bad_strb, 0);

    $display("[TB] reset during WR_B");
    aw_dly = 3;
    cmd_a = 32'd50; cmd_b = 32'd60; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    guard_main = 0;
    while (wr_count % 2 == 0 && guard_main < 50) begin @(negedge clk); guard_main++; end
    checkOutput("wr_b_active", awvalid, 1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    checkOutput("midrst_idle", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    aw_dly = 0;
    @(negedge clk);
    applyStimulus(32'd3, 32'd4, 0, 1'b0);

`ifdef ADDER_CTRL_TIMEOUT_EN
    $display("[TB] watchdog on stuck arready");
    ar_dly = 100000;
    cmd_a = 32'd9; cmd_b = 32'd9; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat_main = 1;
    while (!rsp_valid && lat_main < 100) begin @(negedge clk); lat_main++; end
    checkOutput("to_latency", lat_main, 7);
    checkOutput("to_err", rsp_err, 1);
    checkOutput("to_sum", rsp_sum, 0);
    checkOutput("to_bus_idle", {arvalid, rready}, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    ar_dly = 0;
    applyStimulus(32'd1, 32'd2, 0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_axil_ctrl.md
# adder_axil_ctrl

AXI4-Lite master sequencer that drives the memory-mapped adder slave for a single client. Accepts one job (two operands) on a valid/ready command port. Writes operand A and operand B, then reads back the sum and the overflow flag. Returns all three on a valid/ready response port. Sits between a compute client and the adder's s1_axi slave port, so the client never touches bus protocol.

## Interface
- DATA_WIDTH, 32, data bus and operand width; multiple of 8
- ADDR_WIDTH, 8, AXI address width
- BASE_ADDR, 0, slave base; registers at BASE_ADDR+0 (A), +4 (B), +8 (sum), +12 (overflow)
- TIMEOUT_CYCLES, 255, per-phase watchdog limit (used only with ADDER_CTRL_TIMEOUT_EN); valid range 1 to 65535
- m1_axi_aclk  in  1  single clock, all logic on rising edge
- m1_axi_areset  in  1  reset, asynchronous, active-high
- cmd_valid / cmd_ready  in / out  1 / 1  job handshake
- cmd_a, cmd_b  in  DATA_WIDTH  operands, sampled on cmd handshake
- rsp_valid / rsp_ready  out / in  1 / 1  result handshake
- rsp_sum  out  DATA_WIDTH  sum read from +8
- rsp_ovf  out  1  rdata[0] read from +12
- rsp_err  out  1  sticky error for the job
- m1_axi_awaddr  out  ADDR_WIDTH
- m1_axi_awvalid / m1_axi_awready  out / in  1 / 1
- m1_axi_wdata  out  DATA_WIDTH
- m1_axi_wstrb  out  DATA_WIDTH/8
- m1_axi_wvalid / m1_axi_wready  out / in  1 / 1
- m1_axi_bresp  in  2
- m1_axi_bvalid / m1_axi_bready  in / out  1 / 1
- m1_axi_araddr  out  ADDR_WIDTH
- m1_axi_arvalid / m1_axi_arready  out / in  1 / 1
- m1_axi_rdata  in  DATA_WIDTH
- m1_axi_rresp  in  2
- m1_axi_rvalid / m1_axi_rready  in / out  1 / 1

## Operation
- FSM states: IDLE, WR_A, WR_B, RD_SUM, RD_OVF, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd handshake, latch cmd_a and cmd_b, clear rsp_err, go to WR_A.
- WR_A and WR_B:
  - Drive awaddr to the register offset and wdata to the latched operand; wstrb is all ones.
  - On phase entry, assert awvalid, wvalid and bready together. Each drops only after its own handshake.
  - Sticky done flags aw_done, w_done and b_done complete in any order, including the same cycle.
  - The phase ends when all three flags are set.
  - bready is held from phase entry because the adder slave requires bready while AW/W are pending.
- RD_SUM and RD_OVF:
  - Assert arvalid and rready together on entry; araddr is the register offset.
  - arvalid drops after the AR handshake.
  - rready drops after the R handshake. On that handshake, capture rdata into rsp_sum (RD_SUM), or rdata[0] into rsp_ovf (RD_OVF).
  - The phase ends when both ar_done and r_done are set.
- Errors:
  - Any bresp or rresp with bit[1]=1 (SLVERR/DECERR) sets rsp_err.
  - The sequence still runs to completion.
- DONE:
  - rsp_valid=1; outputs are stable until rsp_ready.
  - On handshake, go to IDLE.
- Only one job is in flight; cmd_ready=0 outside IDLE.

## Timing
- All outputs are registered except cmd_ready, which is decoded from the IDLE state register.
- Reset values: every valid and ready output is 0. All address and data outputs, wstrb, rsp_sum, rsp_ovf and rsp_err are 0. State is IDLE.
- Minimum latency, zero-wait slave: cmd accepted at edge 0, then WR_A in cycle 1, WR_B in 2, RD_SUM in 3, RD_OVF in 4, rsp_valid in cycle 5.
- Each slave wait cycle in a phase adds exactly one cycle.
- Back-to-back throughput: cmd_ready returns in the cycle after the rsp handshake, so at best one job per 6 cycles.
- Reset asserted mid-job clears all state and outputs immediately, without waiting for the clock. A partially issued slave transaction is abandoned; this is permitted.
- rsp_valid must not drop and rsp data must not change while rsp_ready=0.

## Configuration
- Macro: ADDER_CTRL_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counter resets on every phase entry and counts each cycle the phase is incomplete.
  - When the count reaches TIMEOUT_CYCLES, all AXI valids and readies drop, rsp_err is set, rsp_sum is forced to 0, and the FSM goes to DONE.
- Undefined:
  - No counter is built and phases wait indefinitely.

## Test plan
- Zero-wait slave, A=5, B=7: rsp_sum=12, rsp_ovf=0, rsp_err=0, rsp_valid 5 cycles after the cmd handshake.
- A=0xFFFFFFFF, B=1: rsp_sum=0, rsp_ovf=1. Separately, hold rsp_ready=0 for 10 cycles: rsp stays stable and cmd_ready stays 0.
- Slave awready delayed 3 cycles, wready immediate, bvalid 1 cycle after wready: each write phase completes only after all three flags are set, and latency grows by 3 per write.
- Slave returns rresp=2'b10 on the sum read: the job completes with rsp_err=1 and the overflow read is still issued.
- Macro defined, TIMEOUT_CYCLES=4, arready never asserted: DONE is reached 4 cycles into RD_SUM with rsp_err=1 and rsp_sum=0. The next job with a good slave gives rsp_err=0.
- Reset asserted in WR_B: all valids are 0 immediately and state is IDLE. After release, the job A=3, B=4 returns 7.
